// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage with single-entry stall buffer
//
// Purpose: holds the PC, issues one instruction-memory request at a time over a
// req/ready handshake, applies EX redirects (including those that arrive while a
// request is still outstanding), buffers one returned word while decode is stalled,
// and drives the IF/ID pipeline register.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   PCSrcE, PCTargetE     redirect request and target from EX (target bits [1:0] ignored)
//   StallD, FlushD        hazard unit hold / bubble controls for IF/ID
//   imem_req, imem_addr   instruction memory request valid and address (always PCF)
//   imem_ready, imem_rdata memory response; handshake completes on imem_req & imem_ready
//   InstrD, PCD, PCPlus4D IF/ID instruction, PC and PC+4
//   ValidD                IF/ID holds a real instruction

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding at PCF
    S_KILL  = 2'd1,  // request outstanding, but its data belongs to the wrong path
    S_HOLD  = 2'd2   // one word parked in the buffer while decode is stalled
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] kill_target_q, kill_target_d;
  logic [31:0] buf_instr_q, buf_pc_q;
  logic        buf_capture;
  logic        req_state;

  logic [31:0] instr_d, pcd_d, pc_plus4d_d;
  logic        valid_d;

  logic [31:0] pcf_plus4;
  logic [31:0] buf_pc_plus4;
  logic [31:0] target;

  // Masking rather than slicing keeps every target bit in use.
  assign target       = PCTargetE & 32'hFFFF_FFFC;
  assign pcf_plus4    = pcf_q + 32'd4;
  assign buf_pc_plus4 = buf_pc_q + 32'd4;

  assign imem_addr = pcf_q;
  // Gate with rst_n so no request is visible while reset is held.
  assign imem_req  = rst_n & req_state;

  // Next-state, PC and buffer-capture logic.
  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    kill_target_d = kill_target_q;
    buf_capture   = 1'b0;
    req_state     = 1'b1;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          if (PCSrcE) begin
            // Returned word is on the wrong path: drop it.
            pcf_d = target;
          end else begin
            pcf_d = pcf_plus4;
            if (StallD) begin
              buf_capture = 1'b1;
              state_d     = S_HOLD;
            end
          end
        end else if (PCSrcE) begin
          // Address must stay stable until the pending request completes,
          // so remember the target and discard the response when it lands.
          kill_target_d = target;
          state_d       = S_KILL;
        end
      end

      S_KILL: begin
        if (imem_ready) begin
          pcf_d   = PCSrcE ? target : kill_target_q;
          state_d = S_FETCH;
        end else if (PCSrcE) begin
          kill_target_d = target;
        end
      end

      S_HOLD: begin
        req_state = 1'b0;
        if (PCSrcE) begin
          pcf_d   = target;
          state_d = S_FETCH;
        end else if (!StallD) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // IF/ID next value, highest priority first.
  always_comb begin
    instr_d     = InstrD;
    pcd_d       = PCD;
    pc_plus4d_d = PCPlus4D;
    valid_d     = ValidD;

    if (StallD && !FlushD) begin
      // hold everything
    end else if (FlushD || PCSrcE) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (state_q == S_HOLD) begin
      instr_d     = buf_instr_q;
      pcd_d       = buf_pc_q;
      pc_plus4d_d = buf_pc_plus4;
      valid_d     = 1'b1;
    end else if ((state_q == S_FETCH) && imem_ready) begin
      instr_d     = imem_rdata;
      pcd_d       = pcf_q;
      pc_plus4d_d = pcf_plus4;
      valid_d     = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pcf_q         <= RESET_PC;
      kill_target_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pcf_q         <= pcf_d;
      kill_target_q <= kill_target_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'd0;
    end else if (buf_capture) begin
      buf_instr_q <= imem_rdata;
      buf_pc_q    <= pcf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else begin
      InstrD   <= instr_d;
      PCD      <= pcd_d;
      PCPlus4D <= pc_plus4d_d;
      ValidD   <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage

module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h0000_0013;
  endfunction

  assign imem_rdata = imem_ready ? word_of(imem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        ready;
    logic        pcsrc;
    logic [31:0] target;
    logic        stall;
    logic        flush;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic        push;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic p, input logic [31:0] t,
                              input logic s, input logic f, input logic er,
                              input logic [31:0] ea, input logic ev, input logic pu);
    vec_t v;
    v.ready = r; v.pcsrc = p; v.target = t; v.stall = s; v.flush = f;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.push = pu;
    return v;
  endfunction

  int          n_checks;
  int          n_fail;
  logic [31:0] sb[$];
  logic        held_prev;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // At a falling edge: compare outputs, pop the scoreboard on a fresh IF/ID load,
  // then drive this row's inputs for the next rising edge.
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] pc;
    @(negedge clk);
    chk({tag, " req"},   {31'd0, imem_req}, {31'd0, v.exp_req});
    chk({tag, " addr"},  imem_addr, v.exp_addr);
    chk({tag, " valid"}, {31'd0, ValidD}, {31'd0, v.exp_valid});
    if (ValidD && !held_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s sb_unexpected: got PCD %h expected no instruction", tag, PCD);
      end else begin
        pc = sb.pop_front();
        chk({tag, " sb_pcd"},   PCD, pc);
        chk({tag, " sb_instr"}, InstrD, word_of(pc));
        chk({tag, " sb_pc4"},   PCPlus4D, pc + 32'd4);
      end
    end
    imem_ready = v.ready;
    PCSrcE     = v.pcsrc;
    PCTargetE  = v.target;
    StallD     = v.stall;
    FlushD     = v.flush;
    held_prev  = v.stall & ~v.flush;
    if (v.push) sb.push_back(v.exp_addr);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, " addr"},  imem_addr, RESET_PC);
    chk({tag, " valid"}, {31'd0, ValidD}, 32'd0);
    chk({tag, " instr"}, InstrD, NOP_INSTR);
    chk({tag, " pcd"},   PCD, 32'd0);
    chk({tag, " pc4"},   PCPlus4D, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    held_prev  = 1'b0;
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = 32'd0;
    StallD     = 1'b0;
    FlushD     = 1'b0;

    //            rdy pcs target         stl fls req addr           vld push
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0000, 0, 1));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0004, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0008, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_000C, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,         1, 0, 1, 32'h0000_0010, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,         1, 0, 0, 32'h0000_0014, 1, 0));
    tbl.push_back(mk(1, 0, 32'h0,         1, 0, 0, 32'h0000_0014, 1, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 32'h0000_0014, 1, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0014, 1, 1));
    tbl.push_back(mk(0, 1, 32'h80,        0, 0, 1, 32'h0000_0018, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_0018, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0018, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0080, 0, 1));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0084, 1, 1));
    tbl.push_back(mk(1, 1, 32'h200,       0, 0, 1, 32'h0000_0088, 1, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0200, 0, 1));
    tbl.push_back(mk(1, 0, 32'h0,         1, 1, 1, 32'h0000_0204, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 32'h0000_0208, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0208, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_020C, 1, 0));
    tbl.push_back(mk(0, 1, 32'h300,       0, 0, 1, 32'h0000_020C, 0, 0));
    tbl.push_back(mk(0, 1, 32'h400,       0, 0, 1, 32'h0000_020C, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_020C, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0400, 0, 1));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0404, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_0408, 1, 0));
    tbl.push_back(mk(0, 1, 32'h500,       0, 0, 1, 32'h0000_0408, 0, 0));
    tbl.push_back(mk(1, 1, 32'h602,       0, 0, 1, 32'h0000_0408, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0600, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_0604, 1, 0));
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h0000_0604, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'hFFFF_FFFC, 0, 1));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h0000_0000, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_0004, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_0004, 0, 0));

    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end
    chk("table sb_empty", sb.size(), 32'd0);

    // Redirect while the request is pending, then reset in the middle of KILL.
    apply(mk(0, 1, 32'h700, 0, 0, 1, 32'h4, 0, 0), "kill0");
    apply(mk(0, 0, 32'h0,   0, 0, 1, 32'h4, 0, 0), "kill1");
    @(negedge clk);
    rst_n      = 1'b0;
    PCSrcE     = 1'b0;
    imem_ready = 1'b1;
    #1;
    chk_reset_state("midkill_reset");
    repeat (2) @(negedge clk);
    chk_reset_state("late_ready");
    imem_ready = 1'b0;
    rst_n      = 1'b1;
    held_prev  = 1'b0;
    apply(mk(1, 0, 32'h0, 0, 0, 1, 32'h0, 0, 1), "post0");
    apply(mk(0, 0, 32'h0, 0, 0, 1, 32'h4, 1, 0), "post1");
    apply(mk(0, 0, 32'h0, 0, 0, 1, 32'h4, 0, 0), "post2");
    chk("final sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
